// File: rtl/sm_clk_pkg.sv
// Shared state encoding and default sizing for the sm_clk_ctrl divided-clock controller.
// Optional single-step support is enabled with the SM_CLK_STEP_EN macro.
package sm_clk_pkg;

  localparam int CntWDefault  = 32;
  localparam int ShiftDefault = 16;
  localparam int DivWDefault  = 4;

  typedef enum logic [1:0] {
    StStop = 2'd0,
    StRun  = 2'd1,
    StStep = 2'd2,
    StHalt = 2'd3
  } clk_state_e;

  function automatic logic is_busy(input clk_state_e st);
    return (st == StStep) || (st == StHalt);
  endfunction

endpackage

// File: rtl/sm_metafilter.sv
// Two-flop synchroniser for asynchronous control inputs; resets to all zeros.
module sm_metafilter #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/sm_clk_ctrl.sv
// Programmable clock divider with free-run, clean stop and single-step control.
// Single-step is compiled in only when SM_CLK_STEP_EN is defined.
module sm_clk_ctrl
  import sm_clk_pkg::*;
#(
  parameter int CNT_W = CntWDefault,
  parameter int SHIFT = ShiftDefault,
  parameter int DIV_W = DivWDefault
) (
  input  logic             clkIn,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] devide,
  input  logic             enable,
  input  logic             step,
  output logic             clkOut,
  output logic             clkRise,
  output logic             busy
);

  clk_state_e       state_q;
  logic [CNT_W-1:0] cntr_q;
  logic [CNT_W-1:0] cntr_adv;
  logic [CNT_W-1:0] low_mask;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] dev_s;
  logic             en_s;
  logic             tap;
  logic             boundary;
  logic             clk_out_q;
  logic             clk_rise_q;
  int unsigned      tap_idx;

  sm_metafilter #(.WIDTH(DIV_W)) u_sync_div (
    .clk   (clkIn),
    .rst_n (rst_n),
    .d     (devide),
    .q     (dev_s)
  );

  sm_metafilter #(.WIDTH(1)) u_sync_en (
    .clk   (clkIn),
    .rst_n (rst_n),
    .d     (enable),
    .q     (en_s)
  );

`ifdef SM_CLK_STEP_EN
  logic step_s;
  logic step_prev_q;
  logic step_req;

  sm_metafilter #(.WIDTH(1)) u_sync_step (
    .clk   (clkIn),
    .rst_n (rst_n),
    .d     (step),
    .q     (step_s)
  );

  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      step_prev_q <= 1'b0;
    end else begin
      step_prev_q <= step_s;
    end
  end

  assign step_req = step_s & ~step_prev_q;
`else
  logic unused_step;
  assign unused_step = step;
`endif

  // A counter period is the low half followed by the high half, so the boundary
  // (low bits zero) always falls on a clkOut falling edge and phases stay whole.
  assign tap_idx  = SHIFT + 32'(div_q);
  assign tap      = |(cntr_q & (CNT_W'(1) << tap_idx));
  assign low_mask = ~({CNT_W{1'b1}} << (tap_idx + 1));
  assign boundary = ~|(cntr_q & low_mask);
  // At a boundary the counter restarts as if cleared then incremented.
  assign cntr_adv = boundary ? CNT_W'(1) : cntr_q + CNT_W'(1);

  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StStop;
      cntr_q     <= '0;
      div_q      <= '0;
      clk_out_q  <= 1'b0;
      clk_rise_q <= 1'b0;
    end else begin
      clk_out_q  <= tap;
      clk_rise_q <= tap & ~clk_out_q;
      if (boundary || (state_q == StStop)) begin
        div_q <= dev_s;
      end
      unique case (state_q)
        StStop: begin
          cntr_q <= '0;
          if (en_s) begin
            state_q <= StRun;
          end
`ifdef SM_CLK_STEP_EN
          else if (step_req) begin
            state_q <= StStep;
          end
`endif
        end
        StRun: begin
          if (!en_s && !tap) begin
            state_q <= StStop;
            cntr_q  <= '0;
          end else begin
            cntr_q <= cntr_adv;
            if (!en_s) begin
              state_q <= StHalt;
            end
          end
        end
        StHalt: begin
          if (en_s) begin
            state_q <= StRun;
            cntr_q  <= cntr_adv;
          end else if (!tap) begin
            state_q <= StStop;
            cntr_q  <= '0;
          end else begin
            cntr_q <= cntr_adv;
          end
        end
`ifdef SM_CLK_STEP_EN
        StStep: begin
          // Entry sees a zero counter; the next boundary ends the single period.
          if (boundary && (cntr_q != '0)) begin
            if (en_s) begin
              state_q <= StRun;
              cntr_q  <= cntr_adv;
            end else begin
              state_q <= StStop;
              cntr_q  <= '0;
            end
          end else begin
            cntr_q <= cntr_adv;
          end
        end
`endif
        default: begin
          state_q <= StStop;
          cntr_q  <= '0;
        end
      endcase
    end
  end

  assign clkOut  = clk_out_q;
  assign clkRise = clk_rise_q;
  assign busy    = is_busy(state_q);

endmodule

// File: tb/tb_sm_clk_ctrl.sv
// Self-checking bench for sm_clk_ctrl (SHIFT=1): vector table, directed corners, random vs model.
module tb_sm_clk_ctrl;

  localparam int CNT_W = 32;
  localparam int SHIFT = 1;
  localparam int DIV_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [DIV_W-1:0] devide = '0;
  logic             enable = 1'b0;
  logic             step = 1'b0;
  logic             clk_out;
  logic             clk_rise;
  logic             busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sm_clk_ctrl #(.CNT_W(CNT_W), .SHIFT(SHIFT), .DIV_W(DIV_W)) dut (
    .clkIn   (clk),
    .rst_n   (rst_n),
    .devide  (devide),
    .enable  (enable),
    .step    (step),
    .clkOut  (clk_out),
    .clkRise (clk_rise),
    .busy    (busy)
  );

  // Reference model: position inside the current period plus an operating mode.
  localparam int MIdle = 0, MFree = 1, MSingle = 2, MDrain = 3;
  int mode, pos, divm;
  bit started, m_clk, m_rise, m_busy, stp_prev;
  bit en_d[2];
  bit stp_d[2];
  int dev_d[2];

  function automatic int per(input int d);
    return 1 << (SHIFT + d + 1);
  endfunction

  task automatic model_reset();
    mode = MIdle; pos = 0; divm = 0; started = 0;
    m_clk = 0; m_rise = 0; m_busy = 0; stp_prev = 0;
    en_d = '{0, 0}; stp_d = '{0, 0}; dev_d = '{0, 0};
  endtask

  task automatic advance(input int dev_s);
    if (pos == 0) divm = dev_s;
    pos = (pos + 1) % per(divm);
  endtask

  task automatic model_edge();
    bit en_s, st_s, req, tap;
    int dev_s;
    en_s = en_d[1]; st_s = stp_d[1]; dev_s = dev_d[1];
    en_d[1] = en_d[0]; en_d[0] = enable;
    stp_d[1] = stp_d[0]; stp_d[0] = step;
    dev_d[1] = dev_d[0]; dev_d[0] = int'(devide);
    req = st_s && !stp_prev;
    stp_prev = st_s;
`ifndef SM_CLK_STEP_EN
    req = 0;
`endif
    tap = pos >= per(divm) / 2;
    m_rise = tap && !m_clk;
    m_clk = tap;
    case (mode)
      MIdle: begin
        pos = 0; divm = dev_s;
        if (en_s) mode = MFree;
        else if (req) begin mode = MSingle; started = 0; end
      end
      MFree: begin
        if (!en_s && !tap) begin mode = MIdle; pos = 0; end
        else begin
          if (!en_s) mode = MDrain;
          advance(dev_s);
        end
      end
      MDrain: begin
        if (en_s) begin mode = MFree; advance(dev_s); end
        else if (!tap) begin mode = MIdle; pos = 0; end
        else advance(dev_s);
      end
      default: begin
        if (pos == 0 && started) begin
          if (en_s) begin mode = MFree; advance(dev_s); end
          else begin mode = MIdle; pos = 0; end
        end else begin
          advance(dev_s); started = 1;
        end
      end
    endcase
    m_busy = (mode == MSingle) || (mode == MDrain);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_rise(input int limit, output int n);
    n = 0;
    while (clk_rise !== 1'b1 && n < limit) begin tick(); n++; end
    total++;
    if (clk_rise !== 1'b1) begin
      bad++;
      $display("FAIL rise timeout: no clkRise within %0d cycles, expected one", limit);
    end
  endtask

  // Called on a rise: length of the high run, then of the low run up to the next rise.
  task automatic measure(output int hi, output int lo);
    hi = 0; lo = 0;
    while (clk_out === 1'b1 && hi < 200) begin hi++; tick(); end
    while (clk_out === 1'b0 && lo < 200) begin lo++; tick(); end
  endtask

  typedef struct {
    logic             en;
    logic [DIV_W-1:0] dev;
    logic             stp;
    logic             clk;
    logic             rise;
    logic             bsy;
  } vec_t;

  vec_t vecs[17];

  initial begin
    int n, hi, lo, stray, blen, rises;
    bit saw_busy;
    model_reset();

    // Run from reset release, then drop enable with the counter in its high half.
    for (int i = 0; i < 17; i++) begin
      vecs[i] = '{en: (i < 12), dev: '0, stp: 1'b0, clk: 1'b0, rise: 1'b0, bsy: 1'b0};
    end
    foreach (vecs[i]) if (i inside {5, 6, 9, 10, 13, 14}) vecs[i].clk = 1'b1;
    foreach (vecs[i]) if (i inside {5, 9, 13}) vecs[i].rise = 1'b1;
    vecs[14].bsy = 1'b1;

    #12;
    check("reset clkOut", clk_out, 0);
    check("reset clkRise", clk_rise, 0);
    check("reset busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 17; i++) begin
      enable = vecs[i].en; devide = vecs[i].dev; step = vecs[i].stp;
      tick();
      check($sformatf("vec%0d clkOut", i), clk_out, vecs[i].clk);
      check($sformatf("vec%0d clkRise", i), clk_rise, vecs[i].rise);
      check($sformatf("vec%0d busy", i), busy, vecs[i].bsy);
    end

    // Divide change during a high phase takes effect only at a boundary.
    enable = 1'b1; devide = '0;
    wait_rise(100, n);
    devide = DIV_W'(2);
    measure(hi, lo);
    check("div chg old hi", hi, 2);
    check("div chg old lo", lo, 2);
    measure(hi, lo);
    check("div chg mid hi", hi, 2);
    check("div chg new lo", lo, 8);
    measure(hi, lo);
    check("div chg new hi", hi, 8);
    check("div chg new period", hi + lo, 16);

    // Stop requested in the high phase: full-length high, then quiet.
    enable = 1'b0;
    repeat (40) tick();
    devide = DIV_W'(1); enable = 1'b1;
    wait_rise(100, n);
    enable = 1'b0;
    hi = 0; saw_busy = 0;
    while (clk_out === 1'b1 && hi < 100) begin
      hi++; tick();
      if (busy === 1'b1) saw_busy = 1;
    end
    check("halt high len", hi, 4);
    check("halt busy seen", saw_busy, 1);
    stray = 0;
    repeat (20) begin tick(); if (clk_out !== 1'b0 || busy !== 1'b0) stray++; end
    check("halt then quiet", stray, 0);

`ifdef SM_CLK_STEP_EN
    // Single step with devide=1; a second pulse inside the period is dropped.
    step = 1'b1; tick(); step = 1'b0; n = 1;
    while (busy !== 1'b1 && n < 20) begin tick(); n++; end
    check("step latency", n, 3);
    blen = 0; hi = 0; rises = 0;
    while (busy === 1'b1 && blen < 50) begin
      blen++;
      hi += int'(clk_out === 1'b1);
      rises += int'(clk_rise === 1'b1);
      if (blen == 2) step = 1'b1;
      if (blen == 3) step = 1'b0;
      tick();
    end
    check("step busy len", blen, 9);
    check("step high len", hi, 4);
    check("step rises", rises, 1);
    check("step end clkOut", clk_out, 0);
    stray = 0;
    repeat (30) begin tick(); if (clk_out !== 1'b0 || busy !== 1'b0) stray++; end
    check("step 2nd pulse ignored", stray, 0);
`else
    stray = 0;
    for (int i = 0; i < 40; i++) begin
      step = (i % 6) < 2;
      tick();
      if (clk_out !== 1'b0 || busy !== 1'b0) stray++;
    end
    step = 1'b0;
    check("step ignored", stray, 0);
`endif

    // Asynchronous reset in a high phase, then deterministic restart.
    devide = '0; enable = 1'b1;
    wait_rise(100, n);
    #3;
    rst_n = 1'b0;
    #1;
    check("async rst clkOut", clk_out, 0);
    check("async rst clkRise", clk_rise, 0);
    check("async rst busy", busy, 0);
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_rise(50, n);
    check("first rise after rst", n, 6);

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      if ($urandom_range(0, 59) == 0) devide = DIV_W'($urandom_range(0, 2));
      step = ($urandom_range(0, 9) == 0);
      tick();
      check("rnd clkOut", clk_out, m_clk);
      check("rnd clkRise", clk_rise, m_rise);
      check("rnd busy", busy, m_busy);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
